// File: rtl/seq_divider32.sv
// -----------------------------------------------------------------------------
// seq_divider32
// Multi-cycle restoring divider. It produces one quotient bit per clock using
// shift-and-subtract, and it handshakes with the control unit through
// start/busy/done.
//
// Optional build macro: DIV_EARLY_OUT_EN
//   When defined, an operation with |dividend| < |divisor| (and a non-zero
//   divisor) skips the iteration phase and finishes one cycle after
//   acceptance. Results are bit-identical with or without the macro.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset_n      in   synchronous active-low reset
//   start        in   request pulse, sampled only in IDLE
//   signed_op    in   1 = two's-complement divide, 0 = unsigned
//   dividend     in   [WIDTH-1:0] numerator, sampled with start
//   divisor      in   [WIDTH-1:0] denominator, sampled with start
//   busy         out  high from the cycle after an accepted start until done
//   done         out  single-cycle pulse when results are valid
//   quotient     out  [WIDTH-1:0] result, held until the next result
//   remainder    out  [WIDTH-1:0] result, held until the next result
//   div_by_zero  out  set with done when divisor == 0, held with the results
// -----------------------------------------------------------------------------
module seq_divider32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    // Two's-complement negation.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return {WIDTH{1'b0}} - x;
    endfunction

    state_t           state_q,     state_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;
    logic             dz_q,        dz_d;
    logic [WIDTH-1:0] quot_q,      quot_d;
    logic [WIDTH-1:0] rem_out_q,   rem_out_d;
    logic [WIDTH-1:0] part_q,      part_d;     // partial remainder magnitude
    logic [WIDTH-1:0] dvd_q,       dvd_d;      // dividend magnitude / quotient bits
    logic [WIDTH-1:0] dvs_q,       dvs_d;      // divisor magnitude
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic             neg_quo_q,   neg_quo_d;
    logic             neg_rem_q,   neg_rem_d;
    logic             op_dz_q,     op_dz_d;
    logic [WIDTH-1:0] orig_q,      orig_d;     // raw dividend for divide-by-zero

    logic [WIDTH-1:0] mag_a_s;
    logic [WIDTH-1:0] mag_b_s;
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   trial_s;
    logic             q_bit_s;

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_out_q;
    assign div_by_zero = dz_q;

    // Operand magnitudes and one restoring-division step.
    always_comb begin
        mag_a_s   = (signed_op && dividend[WIDTH-1]) ? negate(dividend) : dividend;
        mag_b_s   = (signed_op && divisor[WIDTH-1])  ? negate(divisor)  : divisor;
        shifted_s = {part_q, dvd_q[WIDTH-1]};
        // The low WIDTH bits of the shifted remainder are compared with the
        // divisor in a WIDTH+1-bit subtract. Bit WIDTH of the result is the
        // borrow. A set top bit in the shifted value always means the divisor
        // fits, because the partial remainder is always below the divisor.
        trial_s   = {1'b0, shifted_s[WIDTH-1:0]} - {1'b0, dvs_q};
        q_bit_s   = shifted_s[WIDTH] | ~trial_s[WIDTH];
    end

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dz_d      = dz_q;
        quot_d    = quot_q;
        rem_out_d = rem_out_q;
        part_d    = part_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        op_dz_d   = op_dz_q;
        orig_d    = orig_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d    = 1'b1;
                    dz_d      = 1'b0;
                    orig_d    = dividend;
                    neg_quo_d = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_rem_d = signed_op & dividend[WIDTH-1];
                    part_d    = {WIDTH{1'b0}};
                    dvd_d     = mag_a_s;
                    dvs_d     = mag_b_s;
                    cnt_d     = CW'(WIDTH);
                    if (divisor == {WIDTH{1'b0}}) begin
                        op_dz_d = 1'b1;
                        state_d = S_FINISH;
                    end
`ifdef DIV_EARLY_OUT_EN
                    else if (mag_a_s < mag_b_s) begin
                        // Quotient is zero and the remainder is the whole
                        // dividend magnitude, so FINISH can sign it as usual.
                        op_dz_d = 1'b0;
                        part_d  = mag_a_s;
                        dvd_d   = {WIDTH{1'b0}};
                        state_d = S_FINISH;
                    end
`endif
                    else begin
                        op_dz_d = 1'b0;
                        state_d = S_CALC;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                part_d = q_bit_s ? trial_s[WIDTH-1:0] : shifted_s[WIDTH-1:0];
                dvd_d  = {dvd_q[WIDTH-2:0], q_bit_s};
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_FINISH;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
                if (op_dz_q) begin
                    quot_d    = {WIDTH{1'b1}};
                    rem_out_d = orig_q;
                    dz_d      = 1'b1;
                end else begin
                    // Truncation toward zero: the remainder follows the
                    // dividend's sign. Most-negative / -1 wraps naturally.
                    quot_d    = neg_quo_q ? negate(dvd_q)  : dvd_q;
                    rem_out_d = neg_rem_q ? negate(part_q) : part_q;
                    dz_d      = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
            quot_q    <= {WIDTH{1'b0}};
            rem_out_q <= {WIDTH{1'b0}};
            part_q    <= {WIDTH{1'b0}};
            dvd_q     <= {WIDTH{1'b0}};
            dvs_q     <= {WIDTH{1'b0}};
            cnt_q     <= {CW{1'b0}};
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            op_dz_q   <= 1'b0;
            orig_q    <= {WIDTH{1'b0}};
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
            quot_q    <= quot_d;
            rem_out_q <= rem_out_d;
            part_q    <= part_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            op_dz_q   <= op_dz_d;
            orig_q    <= orig_d;
        end
    end

endmodule

// File: tb/tb_seq_divider32.sv
module tb_seq_divider32;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        signed_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int n_applied;
    int n_miscompares;

`ifdef DIV_EARLY_OUT_EN
    localparam bit EO_EN = 1'b1;
`else
    localparam bit EO_EN = 1'b0;
`endif

    seq_divider32 dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .signed_op   (signed_op),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        eo;   // |a| < |b|: eligible for early out
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Runs one operation starting at the next falling edge. Returns the number
    // of rising edges after acceptance until done is seen (-1 on timeout),
    // and whether busy behaved (high until done, low with done).
    // If repulse > 0, start is pulsed with junk operands that many cycles in.
    task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input int repulse, output int lat, output logic busy_ok);
        @(negedge clk);
        start = 1'b1; signed_op = s; dividend = a; divisor = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        while (!done && lat < 100) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (repulse > 0 && lat == repulse) begin
                start = 1'b1; signed_op = ~s; dividend = 32'h0000_0063; divisor = 32'h0000_0005;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        if (!done) lat = -1;
        else if (busy !== 1'b0) busy_ok = 1'b0;
    endtask

    int   lat;
    logic bok;
    int   exp_lat;
    int   stray;

    initial begin
        n_applied = 0;
        n_miscompares = 0;
        start = 1'b0; signed_op = 1'b0; dividend = 32'h0; divisor = 32'h0;

        //          s     dividend       divisor        quotient       remainder      dz    eo
        vecs[0]  = '{1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 1'b0};
        vecs[1]  = '{1'b1, 32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  32'hFFFFFFFE,  1'b0, 1'b0};
        vecs[2]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'h0,         1'b0, 1'b0};
        vecs[3]  = '{1'b0, 32'h1234,      32'h0,         32'hFFFFFFFF,  32'h1234,      1'b1, 1'b0};
        vecs[4]  = '{1'b0, 32'd8,         32'd2,         32'd4,         32'd0,         1'b0, 1'b0};
        vecs[5]  = '{1'b0, 32'd3,         32'd10,        32'd0,         32'd3,         1'b0, 1'b1};
        vecs[6]  = '{1'b1, 32'hFFFF1234,  32'h0,         32'hFFFFFFFF,  32'hFFFF1234,  1'b1, 1'b0};
        vecs[7]  = '{1'b1, 32'd100,       32'hFFFFFFF9,  32'hFFFFFFF2,  32'd2,         1'b0, 1'b0};
        vecs[8]  = '{1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        32'hFFFFFFFE,  1'b0, 1'b0};
        vecs[9]  = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'd1,         32'd0,         1'b0, 1'b0};
        vecs[10] = '{1'b0, 32'h80000000,  32'hFFFFFFFF,  32'd0,         32'h80000000,  1'b0, 1'b1};
        vecs[11] = '{1'b1, 32'hFFFFFFFD,  32'd10,        32'd0,         32'hFFFFFFFD,  1'b0, 1'b1};
        vecs[12] = '{1'b0, 32'hFFFFFFFF,  32'd2,         32'h7FFFFFFF,  32'd1,         1'b0, 1'b0};
        vecs[13] = '{1'b1, 32'h80000000,  32'd2,         32'hC0000000,  32'd0,         1'b0, 1'b0};
        vecs[14] = '{1'b1, 32'd7,         32'h80000000,  32'd0,         32'd7,         1'b0, 1'b1};

        // Reset state
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_dz",   {31'd0, div_by_zero}, 32'd0);
        chk("reset_quot", quotient, 32'd0);
        chk("reset_rem",  remainder, 32'd0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // Table-driven vectors; each new start lands in the previous done cycle.
        for (int i = 0; i < 15; i++) begin
            do_op(vecs[i].s, vecs[i].a, vecs[i].b, 0, lat, bok);
            exp_lat = (vecs[i].dz || (vecs[i].eo && EO_EN)) ? 1 : 33;
            chk($sformatf("v%0d_quot", i), quotient, vecs[i].q);
            chk($sformatf("v%0d_rem", i), remainder, vecs[i].r);
            chk($sformatf("v%0d_dz", i), {31'd0, div_by_zero}, {31'd0, vecs[i].dz});
            chk($sformatf("v%0d_latency", i), lat, exp_lat);
            chk($sformatf("v%0d_busy", i), {31'd0, bok}, 32'd1);
        end

        // Results held after done, and done is a single-cycle pulse.
        @(posedge clk); #1;
        chk("hold_done", {31'd0, done}, 32'd0);
        chk("hold_quot", quotient, 32'd0);
        chk("hold_rem",  remainder, 32'd7);

        // Start re-pulsed during CALC is ignored.
        repeat (3) @(posedge clk);
        do_op(1'b0, 32'd1000, 32'd3, 5, lat, bok);
        chk("repulse_quot", quotient, 32'd333);
        chk("repulse_rem",  remainder, 32'd1);
        chk("repulse_latency", lat, 33);
        chk("repulse_busy", {31'd0, bok}, 32'd1);
        // Nothing was queued by the ignored pulse.
        stray = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done || busy) stray++;
        end
        chk("repulse_no_queue", stray, 0);

        // Reset for one edge mid-CALC aborts the operation.
        do_op(1'b0, 32'd50, 32'd5, 0, lat, bok);
        @(negedge clk);
        start = 1'b1; signed_op = 1'b0; dividend = 32'd77; divisor = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_quot", quotient, 32'd0);
        chk("abort_rem",  remainder, 32'd0);
        chk("abort_dz",   {31'd0, div_by_zero}, 32'd0);
        stray = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done || busy) stray++;
        end
        chk("abort_no_done", stray, 0);
        do_op(1'b0, 32'hFFFFFFFF, 32'd1, 0, lat, bok);
        chk("post_abort_quot", quotient, 32'hFFFFFFFF);
        chk("post_abort_rem",  remainder, 32'd0);
        chk("post_abort_latency", lat, 33);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
        $finish;
    end

endmodule
